// File: rtl/sipo_rx_ctrl_if.sv
`default_nettype none
// ============================================================
// Module  : sipo_rx_ctrl_if
// Purpose : SIPO control and byte valid/ready bundle for sipo_rx_ctrl
// Rev     : 1.0
// ============================================================
interface sipo_rx_ctrl_if;
  logic [7:0] sipo_dout_i;
  logic       sipo_data_o;
  logic       sipo_wr_en_o;
  logic       sipo_rst_o;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i;

  // master = receive controller, slave = SIPO register plus byte consumer
  modport master (
    input  sipo_dout_i,
    input  byte_ready_i,
    output sipo_data_o,
    output sipo_wr_en_o,
    output sipo_rst_o,
    output byte_o,
    output byte_valid_o
  );

  modport slave (
    output sipo_dout_i,
    output byte_ready_i,
    input  sipo_data_o,
    input  sipo_wr_en_o,
    input  sipo_rst_o,
    input  byte_o,
    input  byte_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
// ============================================================
// Module  : sipo_rx_ctrl
// Purpose : times a 1-start/8-data/1-stop serial frame into a SIPO
// Rev     : 1.0
// ============================================================
module sipo_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  wire logic      clk_i,
  input  wire logic      reset_n_i,
  input  wire logic      en_i,
  input  wire logic      rx_i,
  input  wire logic      overrun_clr_i,
  output logic           frame_err_o,
  output logic           overrun_o,
  sipo_rx_ctrl_if.master bus
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_mid  = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_baud;
  logic [c_cnt_w-1:0] w_baud_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_idx_nxt;

  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;
  logic w_rx_fall;
  logic w_term;

  logic w_wr_en;
  logic w_sipo_rst;
  logic w_frame_err;
  logic w_capture;

  logic [7:0] r_byte;
  logic       r_byte_valid;
  logic       r_overrun;

  // Presetting to 1 keeps reset release from looking like a start edge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_s;
  assign w_term    = (r_baud == c_cnt_last);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_wr_en       = 1'b0;
    w_sipo_rst    = 1'b0;
    w_frame_err   = 1'b0;
    w_capture     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (en_i && w_rx_fall) begin
          w_state_nxt = S_START;
          w_sipo_rst  = 1'b1;
        end
      end
      S_START: begin
        if (r_baud == c_cnt_mid) begin
          w_baud_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_term) begin
          w_baud_nxt    = '0;
          w_wr_en       = 1'b1;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_term) begin
          w_baud_nxt = '0;
          if (r_rx_s) begin
            w_capture   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_baud_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase

    // Disabling mid-frame abandons the partial byte and clears the SIPO
    if (r_state != S_IDLE && !en_i) begin
      w_state_nxt = S_IDLE;
      w_baud_nxt  = '0;
      w_sipo_rst  = 1'b1;
      w_wr_en     = 1'b0;
      w_frame_err = 1'b0;
      w_capture   = 1'b0;
    end
  end

  // A capture in the same cycle as ready keeps the new byte valid
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_byte       <= bus.sipo_dout_i;
        r_byte_valid <= 1'b1;
      end else if (bus.byte_ready_i) begin
        r_byte_valid <= 1'b0;
      end

      if (w_capture && r_byte_valid && !bus.byte_ready_i) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.sipo_wr_en_o = w_wr_en;
  assign bus.sipo_data_o  = w_wr_en & r_rx_s;
  assign bus.sipo_rst_o   = w_sipo_rst;
  assign bus.byte_o       = r_byte;
  assign bus.byte_valid_o = r_byte_valid;
  assign frame_err_o      = w_frame_err;
  assign overrun_o        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
`default_nettype none
// ============================================================
// Module  : tb_sipo_rx_ctrl
// Purpose : self-checking bench for sipo_rx_ctrl with a SIPO model
// Rev     : 1.0
// ============================================================
module tb_sipo_rx_ctrl;
  localparam int CPB = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic rx      = 1'b1;
  logic ovr_clr = 1'b0;
  logic ready   = 1'b0;
  logic ferr;
  logic ovr;
  logic [7:0] sipo_q;

  sipo_rx_ctrl_if bus();

  sipo_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .en_i          (en),
    .rx_i          (rx),
    .overrun_clr_i (ovr_clr),
    .frame_err_o   (ferr),
    .overrun_o     (ovr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // SIPO register: first-written bit ends up in bit 0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sipo_q <= 8'h00;
    else if (bus.sipo_rst_o)   sipo_q <= 8'h00;
    else if (bus.sipo_wr_en_o) sipo_q <= {bus.sipo_data_o, sipo_q[7:1]};
  end
  assign bus.sipo_dout_i  = sipo_q;
  assign bus.byte_ready_i = ready;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor samples one unit after the negedge, after inputs have settled
  int   cyc = 0, wr_cnt = 0, rst_cnt = 0, ferr_cnt = 0, data_viol = 0;
  int   rise_cyc = -1, fall_cyc = -1;
  logic valid_q = 1'b0;
  logic bits_q[$];
  int   strobe_q[$];

  always @(negedge clk) begin
    #1;
    cyc++;
    if (bus.sipo_wr_en_o) begin
      wr_cnt++;
      bits_q.push_back(bus.sipo_data_o);
      strobe_q.push_back(cyc);
    end else if (bus.sipo_data_o) begin
      data_viol++;
    end
    if (bus.sipo_rst_o) rst_cnt++;
    if (ferr) ferr_cnt++;
    if (bus.byte_valid_o && !valid_q) rise_cyc = cyc;
    if (!bus.byte_valid_o && valid_q) fall_cyc = cyc;
    valid_q = bus.byte_valid_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int brk, input int tail);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB + (stop ? 0 : brk)) @(negedge clk);
    rx = 1'b1;
    repeat (tail) @(negedge clk);
  endtask

  task automatic clr_mon();
    bits_q.delete();
    strobe_q.delete();
    rise_cyc = -1;
    fall_cyc = -1;
  endtask

  task automatic chk_bits(input string tag, input logic [7:0] d);
    logic [7:0] got;
    int ok;
    got = 8'h00;
    ok  = (strobe_q.size() == 8) ? 1 : 0;
    for (int i = 0; i < bits_q.size() && i < 8; i++) got[i] = bits_q[i];
    for (int i = 1; i < strobe_q.size(); i++)
      if (strobe_q[i] - strobe_q[i-1] != CPB) ok = 0;
    chk({tag, "_bits"}, int'(got), int'(d));
    chk({tag, "_spacing"}, ok, 1);
  endtask

  task automatic wait_wr(input int target);
    int k;
    k = 0;
    while (wr_cnt < target && k < 1000) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("wait_strobes", (wr_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         brk;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0, f0, r0;
    logic [7:0] m_byte, d;
    logic m_valid, m_ovr, stop, rdy;
    int gap, brk;

    vecs[0] = '{8'h3C, 1'b0, 40, 8'hA5, 1'b0, 1};
    vecs[1] = '{8'h11, 1'b1, 0,  8'h11, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 0,  8'h00, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b1, 0};
    vecs[4] = '{8'h80, 1'b0, 0,  8'hFF, 1'b0, 1};
    vecs[5] = '{8'h7E, 1'b1, 0,  8'h7E, 1'b1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_byte",  int'(bus.byte_o), 0);
    chk("rst_valid", int'(bus.byte_valid_o), 0);
    chk("rst_ovr",   int'(ovr), 0);
    chk("rst_ferr",  int'(ferr), 0);
    chk("rst_wr_en", int'(bus.sipo_wr_en_o), 0);
    chk("rst_sipo_rst", int'(bus.sipo_rst_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_start", rst_cnt, 0);

    // 0xA5 with ready held high
    clr_mon();
    r0 = rst_cnt;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 0, 6);
    ready = 1'b0;
    chk("a5_sipo_rst", rst_cnt - r0, 1);
    chk_bits("a5", 8'hA5);
    chk("a5_byte", int'(bus.byte_o), 8'hA5);
    chk("a5_latency", (strobe_q.size() == 8) ? rise_cyc - strobe_q[7] : -1, CPB + 1);
    chk("a5_valid_width", fall_cyc - rise_cyc, 1);
    chk("a5_valid_after", int'(bus.byte_valid_o), 0);

    // Start-bit glitch
    w0 = wr_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_wr", wr_cnt - w0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_valid", int'(bus.byte_valid_o), 0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      clr_mon();
      w0 = wr_cnt; f0 = ferr_cnt; r0 = rst_cnt;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].brk, 6);
      chk($sformatf("vec%0d_byte", v), int'(bus.byte_o), int'(vecs[v].exp_byte));
      chk($sformatf("vec%0d_valid", v), int'(bus.byte_valid_o), int'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_starts", v), rst_cnt - r0, 1);
      chk_bits($sformatf("vec%0d", v), vecs[v].data);
      consume();
      chk($sformatf("vec%0d_consumed", v), int'(bus.byte_valid_o), 0);
    end

    // Overrun, clear, and ready coinciding with capture
    send_frame(8'h01, 1'b1, 0, 6);
    send_frame(8'h02, 1'b1, 0, 6);
    chk("ovr_byte", int'(bus.byte_o), 8'h02);
    chk("ovr_valid", int'(bus.byte_valid_o), 1);
    chk("ovr_set", int'(ovr), 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", int'(ovr), 0);
    consume();
    send_frame(8'h01, 1'b1, 0, 6);
    chk("ovr2_first_valid", int'(bus.byte_valid_o), 1);
    w0 = wr_cnt;
    fork
      send_frame(8'h02, 1'b1, 0, 6);
      begin
        wait_wr(w0 + 8);
        repeat (CPB) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    chk("ovr2_none", int'(ovr), 0);
    chk("ovr2_byte", int'(bus.byte_o), 8'h02);
    chk("ovr2_valid", int'(bus.byte_valid_o), 1);

    // Asynchronous reset in the middle of 0xFF
    w0 = wr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 0, 6);
      begin
        wait_wr(w0 + 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_byte", int'(bus.byte_o), 0);
        chk("mid_rst_valid", int'(bus.byte_valid_o), 0);
        chk("mid_rst_wr_en", int'(bus.sipo_wr_en_o), 0);
        chk("mid_rst_sipo_rst", int'(bus.sipo_rst_o), 0);
        chk("mid_rst_ferr", int'(ferr), 0);
        chk("mid_rst_ovr", int'(ovr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    chk("mid_rst_strobes", wr_cnt - w0, 3);
    chk("mid_rst_no_capture", int'(bus.byte_valid_o), 0);
    clr_mon();
    send_frame(8'h5A, 1'b1, 0, 6);
    chk("after_rst_byte", int'(bus.byte_o), 8'h5A);
    chk_bits("after_rst", 8'h5A);
    consume();

    // Enable dropped mid-frame
    w0 = wr_cnt; r0 = rst_cnt;
    fork
      send_frame(8'h99, 1'b1, 0, 6);
      begin
        wait_wr(w0 + 2);
        @(negedge clk);
        r0 = rst_cnt;
        en = 1'b0;
        @(negedge clk);
        #2;
        chk("en_drop_sipo_rst", rst_cnt - r0, 1);
      end
    join
    chk("en_drop_strobes", wr_cnt - w0, 2);
    chk("en_drop_no_byte", int'(bus.byte_valid_o), 0);
    chk("en_drop_single_rst", rst_cnt - r0, 1);
    en = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b1, 0, 6);
    chk("en_back_byte", int'(bus.byte_o), 8'hC3);
    chk("en_back_valid", int'(bus.byte_valid_o), 1);

    // Randomized frames against a frame-level model
    consume();
    m_byte = 8'hC3; m_valid = 1'b0; m_ovr = 1'b0;
    for (int n = 0; n < 25; n++) begin
      gap = int'($urandom_range(1, 20));
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        m_ovr = 1'b0;
      end
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      brk  = stop ? 0 : int'($urandom_range(0, 30));
      rdy  = 1'($urandom_range(0, 1));
      ready = rdy;
      if (rdy) m_valid = 1'b0;
      clr_mon();
      w0 = wr_cnt; f0 = ferr_cnt;
      send_frame(d, stop, brk, 6);
      if (stop) begin
        if (m_valid && !rdy) m_ovr = 1'b1;
        m_byte  = d;
        m_valid = !rdy;
      end
      chk($sformatf("rnd%0d_byte", n), int'(bus.byte_o), int'(m_byte));
      chk($sformatf("rnd%0d_valid", n), int'(bus.byte_valid_o), int'(m_valid));
      chk($sformatf("rnd%0d_ovr", n), int'(ovr), int'(m_ovr));
      chk($sformatf("rnd%0d_ferr", n), ferr_cnt - f0, stop ? 0 : 1);
      chk_bits($sformatf("rnd%0d", n), d);
    end
    ready = 1'b0;

    chk("data_zero_when_idle", data_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
- Receive sequencer for the 8-bit serial-in/parallel-out register (SIPO_reg).
- Detects and times an asynchronous serial frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Drives the SIPO's write-enable, serial data and clear, then hands the assembled byte to the consumer over a valid/ready interface.
- Sits between the external rx pin and the byte-level logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  receiver enable.
- rx_i  in  1  asynchronous serial line; idle high.
- sipo_dout_i  in  8  parallel output of the SIPO register.
- sipo_data_o  out  1  serial bit to the SIPO.
- sipo_wr_en_o  out  1  one-cycle shift strobe to the SIPO.
- sipo_rst_o  out  1  active-high clear to the SIPO.
- byte_o  out  8  received byte.
- byte_valid_o  out  1  byte_o holds an unconsumed byte.
- byte_ready_i  in  1  consumer accepts byte_o.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  sticky: a byte was overwritten before it was consumed.
- overrun_clr_i  in  1  clears overrun_o.

Behaviour:
- Reset (async, reset_n_i = 0):
  - state IDLE; counters 0.
  - All outputs 0; byte_o = 0x00.
  - Both rx synchronizer flops preset to 1, so reset release cannot look like a start edge.
- rx_i passes through a 2-flop synchronizer (rx_s). All decisions use rx_s and its registered previous value.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - If en_i = 1 and rx_s falls (1 -> 0): go to START, baud counter cleared, sipo_rst_o = 1 for exactly that cycle.
- START:
  - Count to CLKS_PER_BIT/2 - 1, i.e. the middle of the start bit.
  - If rx_s = 0 at that point: go to DATA, counter cleared, bit_idx = 0.
  - Otherwise treat as a glitch and go to IDLE, with no strobe and no error.
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1. At the terminal count: sipo_wr_en_o = 1 for one cycle with sipo_data_o = rx_s; bit_idx increments.
  - The strobe after bit_idx = 7 also moves the FSM to STOP.
  - Strobes are spaced exactly CLKS_PER_BIT cycles apart.
- STOP:
  - At the terminal count, if rx_s = 1:
    - Register byte_o <= sipo_dout_i and set byte_valid_o.
    - If byte_valid_o = 1 and byte_ready_i = 0 in that same cycle, also set overrun_o.
    - Go to IDLE.
  - At the terminal count, if rx_s = 0: frame_err_o pulses for 1 cycle; byte_o and byte_valid_o are unchanged; go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- sipo_data_o is 0 whenever sipo_wr_en_o = 0.
- Handshake:
  - byte_valid_o stays high until a cycle with byte_ready_i = 1, then clears on the next edge.
  - If a new capture and byte_ready_i = 1 fall in the same cycle, the new byte wins: byte_valid_o stays 1, byte_o is updated, and there is no overrun.
- overrun_o clears only on overrun_clr_i = 1 or reset. If a set and a clear coincide, the set wins.
- en_i = 0 in any non-IDLE state: go to IDLE on the next edge with sipo_rst_o pulsed for one cycle. A partial byte is discarded silently, and byte_o and byte_valid_o are untouched.
- Bit ordering belongs to the SIPO. The controller latches sipo_dout_i unmodified. The bench SIPO model places the first-written bit in bit 0.
- Latency: byte_valid_o rises exactly CLKS_PER_BIT + 1 cycles after the 8th sipo_wr_en_o pulse.

Test Plan (CLKS_PER_BIT = 16):
- Idle-high line, send frame 0xA5 with valid stop bit -> one sipo_rst_o pulse, 8 wr_en pulses 16 cycles apart carrying 1,0,1,0,0,1,0,1, then byte_o = 0xA5 and byte_valid_o = 1; ready held high -> valid clears 1 cycle later.
- rx low for 4 cycles, then high -> no sipo_wr_en_o, byte_valid_o = 0, frame_err_o = 0, FSM back in IDLE.
- Frame 0x3C with stop bit = 0 and line held low 40 cycles -> frame_err_o single pulse, byte_valid_o stays 0, no new start until rx returns high; then frame 0x11 -> byte_o = 0x11.
- Frames 0x01 then 0x02 with byte_ready_i = 0 -> byte_o = 0x02, overrun_o = 1; pulse overrun_clr_i -> overrun_o = 0. Repeat with ready asserted exactly at the second capture cycle -> overrun_o stays 0.
- reset_n_i low for 2 cycles after the 3rd data bit of 0xFF -> all outputs 0 immediately; next frame 0x5A -> byte_o = 0x5A.
- en_i dropped mid-frame -> sipo_rst_o pulse, no byte; en_i high with a new frame 0xC3 -> byte_o = 0xC3.
